// File: rtl/ps2_kbd_io_pkg.sv
// ps2_kbd_io_pkg
// Shared constants and types for the PS/2 keyboard I/O port:
//   FRAME_LEN  - bits per PS/2 frame (start, 8 data, parity, stop)
//   BIT_CNT_W  - width of the receiver bit counter
//   READY_BIT  - rd_data bit carrying the FIFO non-empty flag
//   OVF_BIT    - rd_data bit carrying the sticky overflow flag
//   rx_state_t - receiver FSM state encoding
package ps2_kbd_io_pkg;

    localparam int FRAME_LEN = 11;
    localparam int BIT_CNT_W = 4;
    localparam int READY_BIT = 8;
    localparam int OVF_BIT   = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo
// Scan-code FIFO with DEPTH entries of WIDTH bits.
//   cpu_clk, resetn  - clock, asynchronous active-low reset
//   push, din        - write request and data (accepted if not full, or full with a pop)
//   pop              - read request (ignored while empty)
//   dout             - head entry (undefined content while empty)
//   empty, full      - derived from the extra-bit pointers
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             cpu_clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one wrap bit: equal means empty, equal except the wrap bit means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO still succeeds when the head leaves in the same edge;
    // a pop on an empty FIFO never happens, so push+pop on empty is push only.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    assign dout = mem[rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kbd_io.sv
// ps2_kbd_io
// PS/2 keyboard receiver with a scan-code FIFO, read by the CPU through an I/O strobe.
//   cpu_clk, resetn   - system clock, asynchronous active-low reset
//   ps2_clk, ps2_data - keyboard lines, asynchronous to cpu_clk
//   io_rdn            - active-low read strobe; pops the head byte when ready
//   rd_data           - {22'b0, overflow, ready, head byte (0x00 when empty)}
//   ready             - FIFO non-empty
//   overflow          - sticky: a good frame was dropped on a full FIFO
module ps2_kbd_io
    import ps2_kbd_io_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        cpu_clk,
    input  logic        resetn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        io_rdn,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]           clk_sync;
    logic [2:0]           data_sync;
    logic                 ps2_fall;
    logic                 bit_in;

    rx_state_t            state, state_next;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [FRAME_LEN-1:0] frame, frame_next, frame_shift;
    logic [TW-1:0]        to_cnt, to_cnt_next;
    logic                 frame_done;
    logic                 frame_good;

    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [7:0]           fifo_head;
    logic                 drop;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    // Falling edge: the older synchronized sample is 1 and the newer one is 0.
    assign ps2_fall    = clk_sync[2] & ~clk_sync[1];
    assign bit_in      = data_sync[1];
    assign frame_shift = {bit_in, frame[FRAME_LEN-1:1]};

    // Start low, stop high, odd parity over data and parity bits.
    assign frame_good = frame_done & ~frame_shift[0] & frame_shift[FRAME_LEN-1]
                      & (^frame_shift[9:1]);

    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            frame   <= '0;
            to_cnt  <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            frame   <= frame_next;
            to_cnt  <= to_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        frame_next   = frame;
        to_cnt_next  = to_cnt;
        frame_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                to_cnt_next = '0;
                if (ps2_fall && !bit_in) begin
                    state_next   = ST_RECV;
                    bit_cnt_next = BIT_CNT_W'(1);
                    frame_next   = frame_shift;
                end
            end
            ST_RECV: begin
                if (ps2_fall) begin
                    frame_next  = frame_shift;
                    to_cnt_next = '0;
                    if (bit_cnt == BIT_CNT_W'(FRAME_LEN - 1)) begin
                        state_next   = ST_IDLE;
                        bit_cnt_next = '0;
                        frame_done   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Keyboard went quiet mid-frame: abandon the partial frame.
                    state_next   = ST_IDLE;
                    bit_cnt_next = '0;
                    to_cnt_next  = '0;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ready    = ~fifo_empty;
    assign fifo_pop = ~io_rdn & ready;
    assign drop     = frame_good & fifo_full & ~fifo_pop;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .cpu_clk (cpu_clk),
        .resetn  (resetn),
        .push    (frame_good),
        .pop     (fifo_pop),
        .din     (frame_shift[8:1]),
        .dout    (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // A drop in the same edge as a read wins over the read's clear.
    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (!io_rdn) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        rd_data            = '0;
        rd_data[7:0]       = ready ? fifo_head : 8'h00;
        rd_data[READY_BIT] = ready;
        rd_data[OVF_BIT]   = overflow;
    end

endmodule

// File: tb/tb_ps2_kbd_io.sv
// tb_ps2_kbd_io
// Directed bench for ps2_kbd_io: PS/2 frames are bit-banged at 16 cpu_clk cycles per bit,
// CPU reads are single-cycle io_rdn pulses, and all outputs are sampled on the falling
// edge of cpu_clk.
module tb_ps2_kbd_io;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;

    logic        cpu_clk;
    logic        resetn;
    logic        ps2_clk;
    logic        ps2_data;
    logic        io_rdn;
    logic [31:0] rd_data;
    logic        ready;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;

    ps2_kbd_io #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .cpu_clk  (cpu_clk),
        .resetn   (resetn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .io_rdn   (io_rdn),
        .rd_data  (rd_data),
        .ready    (ready),
        .overflow (overflow)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge cpu_clk);
    endtask

    // One PS/2 bit. With pop_here set, io_rdn is pulled low for exactly the cycle in which
    // the synchronized falling edge is visible (two cpu_clk edges after ps2_clk drops).
    task automatic ps2_bit(input logic b, input logic pop_here);
        ps2_data = b;
        cycles(4);
        ps2_clk = 1'b0;
        if (pop_here) begin
            cycles(2);
            io_rdn = 1'b0;
            cycles(1);
            io_rdn = 1'b1;
            cycles(5);
        end else begin
            cycles(8);
        end
        ps2_clk = 1'b1;
        cycles(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_on_stop);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(1'b1, pop_on_stop);
        ps2_data = 1'b1;
    endtask

    task automatic read_word(output logic [31:0] w);
        w = rd_data;
        io_rdn = 1'b0;
        cycles(1);
        io_rdn = 1'b1;
        cycles(1);
    endtask

    logic [31:0] w;

    initial begin
        resetn   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        io_rdn   = 1'b1;
        cycles(3);
        check("reset_rd_data", rd_data, 32'h0000_0000);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        resetn = 1'b1;
        cycles(2);

        // Good frame 0x1C, then one read empties the FIFO.
        send_frame(8'h1C, 1'b0, 1'b0);
        check("good_ready", 32'(ready), 32'd1);
        check("good_rd_data", rd_data, 32'h0000_011C);
        read_word(w);
        check("good_read_word", w, 32'h0000_011C);
        check("good_after_ready", 32'(ready), 32'd0);
        check("good_after_rd_data", rd_data, 32'h0000_0000);

        // Read on an empty FIFO changes nothing.
        read_word(w);
        check("empty_read_word", w, 32'h0000_0000);
        check("empty_read_after", rd_data, 32'h0000_0000);

        // Bad parity is discarded silently.
        send_frame(8'h1C, 1'b1, 1'b0);
        check("badpar_ready", 32'(ready), 32'd0);
        check("badpar_ovf", 32'(overflow), 32'd0);

        // Nine frames into an 8-deep FIFO: 0x09 is dropped and overflow is set.
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_rd_data", rd_data, 32'h0000_0301);
        for (int k = 1; k <= 8; k++) begin
            read_word(w);
            check($sformatf("ovf_read_%0d", k), w, (k == 1) ? 32'h0000_0301 : (32'h100 | 32'(k)));
            if (k == 1) check("ovf_cleared", 32'(overflow), 32'd0);
        end
        check("ovf_drained", rd_data, 32'h0000_0000);

        // Frame abandoned after 5 bits; only the following 0x5A arrives.
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        cycles(TIMEOUT + 1);
        check("timeout_no_data", 32'(ready), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0);
        read_word(w);
        check("timeout_5a", w, 32'h0000_015A);
        check("timeout_only_one", 32'(ready), 32'd0);

        // Full FIFO, read in the same cycle the 9th frame completes.
        for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 1'b0);
        check("full_no_ovf", 32'(overflow), 32'd0);
        send_frame(8'h09, 1'b0, 1'b1);
        check("pushpop_no_ovf", 32'(overflow), 32'd0);
        for (int k = 2; k <= 9; k++) begin
            read_word(w);
            check($sformatf("pushpop_read_%0d", k), w, 32'h100 | 32'(k));
        end
        check("pushpop_drained", 32'(ready), 32'd0);

        // Reset mid-frame after bit 6, then a clean 0xF0.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(1'b1, 1'b0);
        resetn = 1'b0;
        cycles(2);
        check("midreset_rd_data", rd_data, 32'h0000_0000);
        resetn = 1'b1;
        cycles(2);
        send_frame(8'hF0, 1'b0, 1'b0);
        check("midreset_ready", 32'(ready), 32'd1);
        read_word(w);
        check("midreset_f0", w, 32'h0000_01F0);
        check("midreset_no_stale", 32'(ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
